if_id_stage: RTL and testbench

//  Fetch-side pipeline front end: PC register, next-PC selection and IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_id_stage_pc_reg.sv | 21 ++
 rtl/if_id_stage.sv | 107 ++++++++++
 tb/tb_if_id_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble constants, fetch FSM encoding,
// opcode constants and small address helpers.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] pc_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// 32-bit program counter register with load enable.
// Asynchronous active-low reset to RESET_VAL.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= RESET_VAL;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC, next-PC select, IF/ID register and
// saturating stall counter.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hd_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_inst_i,
    input  logic             imem_valid_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    import cpu_pkg::*;

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_inc;
    logic         pc_load;
    logic         active;
    logic         do_redir;
    logic         do_stall;
    logic         do_fetch;

    assign imem_addr_o = pc_q;
    assign pc_inc      = pc_q + 32'd4;
    assign active      = (state_q != BOOT);

    // Mutually exclusive actions, redirect > stall > fetch.
    assign do_redir = active && redirect_i;
    assign do_stall = active && !redirect_i && hd_i;
    assign do_fetch = active && !redirect_i && !hd_i && imem_valid_i;

    always_comb begin
        pc_load = 1'b0;
        pc_d    = pc_q;
        unique case (1'b1)
            do_redir: begin
                pc_load = 1'b1;
                pc_d    = pc_align(redirect_pc_i);
            end
            do_fetch: begin
                pc_load = 1'b1;
                pc_d    = pc_inc;
            end
            default: ;
        endcase
    end

    pc_reg #(
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(pc_load),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= BOOT;
            pc_o        <= 32'h0;
            inst_o      <= NOP_INST;
            valid_o     <= 1'b0;
            stall_cnt_o <= '0;
        end else if (!active) begin
            state_q <= RUN;
        end else begin
            unique case (1'b1)
                do_redir: begin
                    pc_o    <= 32'h0;
                    inst_o  <= NOP_INST;
                    valid_o <= 1'b0;
                    state_q <= RUN;
                end
                do_stall: begin
                    if (stall_cnt_o != {CNT_W{1'b1}}) begin
                        stall_cnt_o <= stall_cnt_o + 1'b1;
                    end
                end
                do_fetch: begin
                    pc_o    <= pc_inc;
                    inst_o  <= imem_inst_i;
                    valid_o <= 1'b1;
                    state_q <= RUN;
                end
                default: begin
                    pc_o    <= 32'h0;
                    inst_o  <= NOP_INST;
                    valid_o <= 1'b0;
                    state_q <= MISS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed + random bench for if_id_stage against a
// behavioural fetch model.
module tb_if_id_stage;

    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        hd;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_addr2;
    logic [31:0] imem_inst;
    logic        imem_valid;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic [15:0] cnt;
    logic [31:0] pc_out2;
    logic [31:0] inst_out2;
    logic        valid_out2;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;

    // behavioural model
    bit          m_boot;
    bit          m_miss;
    logic [31:0] m_pc;
    logic [31:0] m_pc_o;
    logic [31:0] m_inst;
    bit          m_valid;
    int          m_cnt;
    int          m_cnt2;

    if_id_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .hd_i         (hd),
        .redirect_i   (redir),
        .redirect_pc_i(redir_pc),
        .imem_addr_o  (imem_addr),
        .imem_inst_i  (imem_inst),
        .imem_valid_i (imem_valid),
        .pc_o         (pc_out),
        .inst_o       (inst_out),
        .valid_o      (valid_out),
        .stall_cnt_o  (cnt)
    );

    if_id_stage #(.CNT_W(2)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .hd_i         (hd),
        .redirect_i   (redir),
        .redirect_pc_i(redir_pc),
        .imem_addr_o  (imem_addr2),
        .imem_inst_i  (imem_inst),
        .imem_valid_i (imem_valid),
        .pc_o         (pc_out2),
        .inst_o       (inst_out2),
        .valid_o      (valid_out2),
        .stall_cnt_o  (cnt2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C01_0004;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_inst = mem(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1;
        m_miss  = 0;
        m_pc    = RESET_PC;
        m_pc_o  = 32'h0;
        m_inst  = NOP_INST;
        m_valid = 0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 0;
        end else if (redir) begin
            m_pc    = redir_pc & ~32'd3;
            m_valid = 0;
            m_inst  = NOP_INST;
            m_miss  = 0;
        end else if (hd) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (imem_valid) begin
            m_inst  = mem(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc_o  = m_pc;
            m_valid = 1;
            m_miss  = 0;
        end else begin
            m_valid = 0;
            m_inst  = NOP_INST;
            m_miss  = 1;
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("valid", {31'h0, valid_out}, {31'h0, m_valid});
        chk("inst", inst_out, m_inst);
        if (m_valid) chk("pc_o", pc_out, m_pc_o);
        chk("stall_cnt", {16'h0, cnt}, m_cnt);
        chk("stall_cnt2", {30'h0, cnt2}, m_cnt2);
        chk("valid2", {31'h0, valid_out2}, {31'h0, m_valid});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst        = 1'b0;
        hd         = 1'b0;
        redir      = 1'b0;
        redir_pc   = 32'h0;
        imem_valid = 1'b1;
        model_reset();
        #12;
        check_all();
        chk("state_reset", {30'h0, dut.state_q}, {30'h0, BOOT});
        #1 rst = 1'b1;

        // boot cycle, then streaming fetch
        step();
        chk("boot_valid", {31'h0, valid_out}, 32'h0);
        step();
        chk("first_pc_o", pc_out, 32'h4);
        chk("first_inst", inst_out, 32'h8C01_0004);
        step();
        chk("addr8", imem_addr, 32'h8);

        // two-cycle stall at PC 8
        hd = 1'b1;
        step();
        step();
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_cnt2", {16'h0, cnt}, 32'h2);
        hd = 1'b0;
        step();
        chk("resume_pc_o", pc_out, 32'hC);

        // redirect wins over stall
        hd       = 1'b1;
        redir    = 1'b1;
        redir_pc = 32'h103;
        step();
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_cnt", {16'h0, cnt}, 32'h2);

        // miss at 0x20
        hd       = 1'b0;
        redir_pc = 32'h20;
        step();
        redir      = 1'b0;
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("miss_state", {30'h0, dut.state_q}, {30'h0, MISS});
            chk("miss_addr", imem_addr, 32'h20);
        end
        imem_valid = 1'b1;
        step();
        chk("miss_resume", pc_out, 32'h24);

        // wrap at top of address space
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        step();
        redir = 1'b0;
        step();
        chk("wrap_pc_o", pc_out, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // 5 stalls saturate the 2-bit counter
        hd = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt2", {30'h0, cnt2}, 32'h3);

        // async reset mid-stall
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_pc_o", pc_out, 32'h0);
        #2 rst = 1'b1;
        step();
        hd = 1'b0;
        step();
        chk("post_rst_pc_o", pc_out, 32'h4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            hd         = ($urandom_range(0, 3) == 0);
            redir      = ($urandom_range(0, 9) == 0);
            redir_pc   = $urandom;
            imem_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
